// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RISC-V pipeline: ID/EX register with flush,
// operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      RS1D,
    input  logic [4:0]      RS2D,
    input  logic [4:0]      RDD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic            ResultSrcE0,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RDM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
    } id_ex_t;

    id_ex_t id_ex;
    id_ex_t id_ex_next;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    assign id_ex_next = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc_plus4: PCPlus4D,
                          imm_ext: ImmExtD, rs1: RS1D, rs2: RS2D, rd: RDD,
                          reg_write: RegWriteD, mem_write: MemWriteD,
                          jump: JumpD, branch: BranchD, alu_src: ALUSrcD,
                          result_src: ResultSrcD, alu_control: ALUControlD};

    // A flushed slot becomes an all-zero NOP: no writes, no redirect, rd = x0.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex <= '0;
        end else if (FlushE) begin
            id_ex <= '0;
        end else begin
            id_ex <= id_ex_next;
        end
    end

    // Forward select 11 is unused by the hazard unit and falls back to the register value.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        src_a = id_ex.rd1;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = id_ex.rd1;
        endcase
        write_data = id_ex.rd2;
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALUResultM;
            default: write_data = id_ex.rd2;
        endcase
    end

    assign src_b = id_ex.alu_src ? id_ex.imm_ext : write_data;

    always_comb begin
        alu_result = '0;
        case (id_ex.alu_control)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_result = src_a << src_b[4:0];
            3'b111:  alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    assign zero        = (alu_result == '0);
    assign PCTargetE   = id_ex.pc + id_ex.imm_ext;
    assign PCSrcE      = (id_ex.branch & zero) | id_ex.jump;
    assign RS1E        = id_ex.rs1;
    assign RS2E        = id_ex.rs2;
    assign RDE         = id_ex.rd;
    assign ResultSrcE0 = id_ex.result_src[0];

    // EX/MEM carries the forwarded store data, not the raw register read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RDM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else begin
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= id_ex.pc_plus4;
            RDM        <= id_ex.rd;
            RegWriteM  <= id_ex.reg_write;
            MemWriteM  <= id_ex.mem_write;
            ResultSrcM <= id_ex.result_src;
        end
    end

endmodule
